// File: rtl/mindfocus_unidade_controle.sv
// rtl/mindfocus_unidade_controle.sv - MindFocus game control unit (Moore FSM, timeout timer, error counter)
module mindfocus_unidade_controle #(
  parameter int TIMEOUT   = 3000,
  parameter int TW        = 12,
  parameter int MAX_ERROS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       botaoIgualMemoria,
  input  logic       fimE,
  output logic       zeraA,
  output logic       zeraE,
  output logic       zeraR,
  output logic       registraR,
  output logic       contaE,
  output logic       contaA,
  output logic       pronto,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] erros,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL       = 4'd0;
  localparam logic [3:0] PREPARACAO    = 4'd1;
  localparam logic [3:0] ESPERA_JOGADA = 4'd2;
  localparam logic [3:0] REGISTRA      = 4'd3;
  localparam logic [3:0] COMPARACAO    = 4'd4;
  localparam logic [3:0] ACERTO        = 4'd5;
  localparam logic [3:0] ERRO          = 4'd6;
  localparam logic [3:0] PROXIMO       = 4'd7;
  localparam logic [3:0] ESGOTADO      = 4'd8;
  localparam logic [3:0] FIM_COMPLETO  = 4'd9;
  localparam logic [3:0] FIM_ERROS     = 4'd10;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    MAX_E  = 4'(MAX_ERROS);

  logic [3:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    erros_q, erros_d;

  // State sequencing; a play arriving on the last timer cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:       if (iniciar) state_d = PREPARACAO;
      PREPARACAO:    state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada_feita)           state_d = REGISTRA;
        else if (timer_q == T_LAST) state_d = ESGOTADO;
      end
      REGISTRA:      state_d = COMPARACAO;
      COMPARACAO:    state_d = botaoIgualMemoria ? ACERTO : ERRO;
      ACERTO:        state_d = PROXIMO;
      ESGOTADO:      state_d = ERRO;
      ERRO:          state_d = (erros_q + 4'd1 == MAX_E) ? FIM_ERROS : PROXIMO;
      PROXIMO:       state_d = fimE ? FIM_COMPLETO : ESPERA_JOGADA;
      FIM_COMPLETO:  if (iniciar) state_d = PREPARACAO;
      FIM_ERROS:     if (iniciar) state_d = PREPARACAO;
      default:       state_d = INICIAL;
    endcase
  end

  // Timer restarts on each entry to espera and only counts while staying there, so it cannot wrap.
  always_comb begin
    timer_d = timer_q;
    if (state_d == ESPERA_JOGADA && state_q != ESPERA_JOGADA) begin
      timer_d = '0;
    end else if (state_d == ESPERA_JOGADA && state_q == ESPERA_JOGADA) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Error count: cleared at round start, bumped (saturating) once per visit to erro.
  always_comb begin
    erros_d = erros_q;
    if (state_q == PREPARACAO) begin
      erros_d = 4'd0;
    end else if (state_q == ERRO && erros_q < MAX_E) begin
      erros_d = erros_q + 4'd1;
    end
  end

  // State, timer and error registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INICIAL;
      timer_q <= '0;
      erros_q <= 4'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      erros_q <= erros_d;
    end
  end

  // Moore output decode.
  always_comb begin
    zeraA     = 1'b0;
    zeraE     = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    contaE    = 1'b0;
    contaA    = 1'b0;
    pronto    = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zeraA = 1'b1;
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA:     registraR = 1'b1;
      ACERTO:       contaA    = 1'b1;
      ESGOTADO:     timeout   = 1'b1;
      PROXIMO:      contaE    = ~fimE;
      FIM_COMPLETO: pronto    = 1'b1;
      FIM_ERROS: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      default: ;
    endcase
  end

  assign erros     = erros_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_mindfocus_unidade_controle.sv
// tb/tb_mindfocus_unidade_controle.sv - directed self-checking bench for mindfocus_unidade_controle
module tb_mindfocus_unidade_controle;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogada_feita = 1'b0;
  logic       botaoIgualMemoria = 1'b0;
  logic       fimE = 1'b0;
  logic       zeraA, zeraE, zeraR, registraR, contaE, contaA, pronto, errou, timeout;
  logic [3:0] erros, db_estado;
  logic [8:0] outs;

  int checks = 0;
  int failures = 0;
  int na = 0, ne = 0, nt = 0;
  int na0, ne0, nt0, n;

  mindfocus_unidade_controle #(.TIMEOUT(8), .TW(4), .MAX_ERROS(3)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .botaoIgualMemoria(botaoIgualMemoria), .fimE(fimE),
    .zeraA(zeraA), .zeraE(zeraE), .zeraR(zeraR), .registraR(registraR),
    .contaE(contaE), .contaA(contaA), .pronto(pronto), .errou(errou),
    .timeout(timeout), .erros(erros), .db_estado(db_estado)
  );

  assign outs = {zeraA, zeraE, zeraR, registraR, contaE, contaA, pronto, errou, timeout};

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (contaA)  na++;
    if (contaE)  ne++;
    if (timeout) nt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic play(input logic ok, input logic last);
    jogada_feita = 1'b1;
    botaoIgualMemoria = ok;
    fimE = last;
    tick();
    jogada_feita = 1'b0;
    chk("play_registra", db_estado, 3);
    tick();
    tick();
    tick();
    if (db_estado == 4'd7) tick();
    fimE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_state", db_estado, 0);
    chk("rst_outs", outs, 0);
    chk("rst_erros", erros, 0);
    reset = 1'b0;
    tick();
    chk("idle_state", db_estado, 0);

    // full round of 16 correct plays
    iniciar = 1'b1;
    tick();
    chk("prep_state", db_estado, 1);
    chk("prep_outs", outs, 9'b111000000);
    iniciar = 1'b0;
    tick();
    chk("espera_state", db_estado, 2);
    na0 = na; ne0 = ne;
    for (int i = 0; i < 16; i++) play(1'b1, i == 15);
    chk("full_contaA", na - na0, 16);
    chk("full_contaE", ne - ne0, 15);
    chk("full_state", db_estado, 9);
    chk("full_outs", outs, 9'b000000100);
    chk("full_erros", erros, 0);

    // three mismatches abort the round
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("r2_prep", db_estado, 1);
    tick();
    ne0 = ne;
    play(1'b0, 1'b0);
    chk("err1_erros", erros, 1);
    chk("err1_state", db_estado, 2);
    play(1'b0, 1'b0);
    chk("err2_erros", erros, 2);
    play(1'b0, 1'b0);
    chk("err3_erros", erros, 3);
    chk("err3_state", db_estado, 10);
    chk("err3_outs", outs, 9'b000000110);
    chk("err3_contaE", ne - ne0, 2);
    tick();
    tick();
    chk("fim_erros_hold", db_estado, 10);
    chk("fim_erros_hold_erros", erros, 3);

    // restart from fim_erros; iniciar held through espera is ignored
    iniciar = 1'b1;
    tick();
    chk("r3_prep", db_estado, 1);
    tick();
    chk("r3_erros_clear", erros, 0);
    tick();
    tick();
    tick();
    chk("iniciar_ignored", db_estado, 2);
    iniciar = 1'b0;
    na0 = na;
    play(1'b1, 1'b0);
    chk("r3_contaA", na - na0, 1);
    chk("r3_state", db_estado, 2);

    // timeout after exactly TIMEOUT cycles in espera
    nt0 = nt;
    n = 0;
    do begin
      tick();
      n++;
    end while (db_estado != 4'd8 && n < 20);
    chk("timeout_latency", n, 8);
    chk("timeout_outs", outs, 9'b000000001);
    tick();
    chk("to_erro_state", db_estado, 6);
    chk("to_pulse_width", timeout, 0);
    tick();
    chk("to_proximo", db_estado, 7);
    chk("to_erros", erros, 1);
    chk("to_contaE", contaE, 1);
    tick();
    chk("to_back_espera", db_estado, 2);

    // play on the last timer cycle beats the timeout
    for (int i = 0; i < 7; i++) tick();
    chk("edge_still_espera", db_estado, 2);
    play(1'b1, 1'b0);
    chk("edge_no_timeout", nt - nt0, 1);
    chk("edge_erros", erros, 1);
    chk("edge_state", db_estado, 2);

    // asynchronous reset during comparacao
    jogada_feita = 1'b1;
    botaoIgualMemoria = 1'b1;
    tick();
    jogada_feita = 1'b0;
    tick();
    chk("pre_rst_comparacao", db_estado, 4);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", db_estado, 0);
    chk("async_rst_outs", outs, 0);
    chk("async_rst_erros", erros, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", db_estado, 0);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("post_rst_prep_outs", outs, 9'b111000000);
    tick();
    chk("post_rst_espera", db_estado, 2);
    chk("post_rst_outs", outs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mindfocus_unidade_controle.md
Name: mindfocus_unidade_controle

Overview:
- Moore FSM that sequences the MindFocus game datapath: button register, address/hit counters, ROM comparator and button edge detector.
- Clears the datapath, waits for each play and registers it, then compares it and advances the address.
- Counts errors and per-play timeouts internally.
- Ends the round when all 16 positions are played or when the error limit is reached.

Parameters:
- TIMEOUT, 3000, clock cycles allowed in espera_jogada before a play counts as timed out (≥2).
- TW, 12, width of the timeout counter; must satisfy 2^TW ≥ TIMEOUT.
- MAX_ERROS, 3, error count that aborts the round (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces inicial and clears internal counters.
- iniciar  in  1  start/restart request, level sampled each cycle.
- jogada_feita  in  1  one-cycle pulse from the datapath edge detector.
- botaoIgualMemoria  in  1  comparator result (registered button == ROM word).
- fimE  in  1  address counter at terminal value 15.
- zeraA  out  1  clear hit counter.
- zeraE  out  1  clear address counter and edge detector.
- zeraR  out  1  clear button register.
- registraR  out  1  load button register.
- contaE  out  1  increment address.
- contaA  out  1  increment hit counter.
- pronto  out  1  round finished (either end state).
- errou  out  1  round aborted by errors.
- timeout  out  1  one-cycle pulse when a play times out.
- erros  out  4  current error count.
- db_estado  out  4  current state code.

Behaviour:
- All outputs are Moore, decoded from state; only the listed outputs are 1 in each state.
- Reset: state=inicial(0), timer=0, erros=0, all outputs 0, db_estado=0. Reset is honoured mid-operation in any state.
- State codes and transitions:
  - 0 inicial: iniciar=1 → preparacao.
  - 1 preparacao: zeraA=zeraE=zeraR=1; erros cleared; → espera_jogada.
  - 2 espera_jogada: timer increments each cycle, starting at 0 on entry.
    - jogada_feita=1 → registra.
    - else timer==TIMEOUT-1 → esgotado.
    - Both in the same cycle: the play wins.
  - 3 registra: registraR=1; → comparacao.
  - 4 comparacao: botaoIgualMemoria=1 → acerto, else → erro. Compare is valid here because the register loaded on the registra edge.
  - 5 acerto: contaA=1; → proximo.
  - 8 esgotado: timeout=1; → erro.
  - 6 erro: erros increments.
    - If erros+1 == MAX_ERROS → fim_erros.
    - Otherwise → proximo.
  - 7 proximo: fimE=1 → fim_completo; else contaE=1, → espera_jogada. The ROM's one-cycle read latency is covered by espera_jogada lasting at least one cycle.
  - 9 fim_completo: pronto=1; iniciar=1 → preparacao.
  - 10 fim_erros: pronto=1, errou=1; iniciar=1 → preparacao.
  - Codes 11-15 are illegal → inicial on the next edge.
- Timer:
  - Zeroed on every entry to espera_jogada.
  - Held in all other states; it never wraps inside espera.
- erros:
  - 4-bit, saturates at MAX_ERROS.
  - Cleared only by reset or preparacao.
  - Holds its value in the end states for display.
- iniciar is ignored in states 1-8. jogada_feita is ignored outside espera_jogada.
- A play sequence takes 5 cycles minimum (espera, registra, comparacao, acerto/erro, proximo). With a 16-word ROM there are 15 contaE pulses per full round.

Test Plan:
- Reset, then iniciar pulse, then 16 correct plays (jogada_feita with botaoIgualMemoria=1, fimE asserted on the 16th) → 16 contaA pulses, 15 contaE pulses, state 9, pronto=1, errou=0, erros=0.
- MAX_ERROS=3, plays 1-3 mismatched → erros 1,2,3; after the 3rd, state 10, pronto=1, errou=1; no contaE after the 3rd error.
- TIMEOUT=8, no jogada_feita → timeout pulse exactly 8 cycles after entering espera, erros=1, then proximo issues contaE and the timer restarts from 0.
- jogada_feita on the same cycle as timer==TIMEOUT-1 → registra entered, no timeout pulse, erros unchanged.
- Assert reset asynchronously during comparacao (mid-clock) → db_estado=0 immediately, erros=0, all outputs 0; a subsequent iniciar gives a full preparacao (zeraA/E/R=1 for 1 cycle).
- From fim_erros, iniciar=1 → preparacao clears erros to 0 and the round replays normally; iniciar held during espera has no effect.
